// File: rtl/ahb_disp_sequencer.sv
// AHB-Lite frame queue feeding an 8-digit 7-segment driver, one frame per dwell period.
// Optional interrupt logic is built only when DISP_SEQ_IRQ_EN is defined.
module ahb_disp_sequencer #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 24
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        HSEL,
  input  logic        HREADY,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [31:0] HWDATA,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  output logic [31:0] disp_number,
  output logic [7:0]  disp_dp,
  output logic        disp_blank,
  output logic        irq
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

`ifdef DISP_SEQ_IRQ_EN
  localparam logic [3:0] CTRL_MASK = 4'hF;
`else
  localparam logic [3:0] CTRL_MASK = 4'h7;
`endif

  typedef enum logic [1:0] {IDLE, LOAD, DWELL} state_t;

  state_t            state_reg;
  logic [3:0]        ctrl_reg;
  logic [CNT_W-1:0]  interval_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic [7:0]        dpstage_reg;
  logic              ovf_reg;
  logic              pend_wr_reg;
  logic [2:0]        pend_addr_reg;
  logic [PW-1:0]     rd_ptr_reg;
  logic [PW-1:0]     wr_ptr_reg;
  logic [CW-1:0]     count_reg;
  logic [CW-1:0]     count_next;
  logic [31:0]       disp_number_reg;
  logic [7:0]        disp_dp_reg;
  logic              disp_blank_reg;
  logic [39:0]       mem [DEPTH];

  logic en, loop, empty, full, load_go, stall, commit;
  logic pop, loop_push, push_req, push_ok;
  logic [CNT_W-1:0] dwell_load;
  logic unused_bits;

  assign unused_bits = ^{HADDR[31:5], HADDR[1:0], HTRANS[0]};

  assign en         = ctrl_reg[0];
  assign loop       = ctrl_reg[1];
  assign empty      = (count_reg == '0);
  assign full       = (count_reg == CW'(DEPTH));
  assign load_go    = (state_reg == LOAD) && en;
  // A push cannot share the single FIFO write port with a loop re-push, so it waits one cycle.
  assign stall      = pend_wr_reg && (pend_addr_reg == 3'd3) && load_go && loop;
  assign HREADYOUT  = !stall;
  assign commit     = pend_wr_reg && !stall;
  assign pop        = load_go && !empty;
  assign loop_push  = pop && loop;
  assign push_req   = commit && (pend_addr_reg == 3'd3);
  assign push_ok    = push_req && (!full || (pop && !loop));
  assign dwell_load = (interval_reg == '0) ? CNT_W'(1) : interval_reg;

  always_comb begin
    count_next = count_reg;
    case ({push_ok, pop && !loop})
      2'b10:   count_next = count_reg + CW'(1);
      2'b01:   count_next = count_reg - CW'(1);
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      pend_wr_reg   <= 1'b0;
      pend_addr_reg <= 3'd0;
      ctrl_reg      <= 4'd0;
      interval_reg  <= '0;
      dpstage_reg   <= 8'd0;
      ovf_reg       <= 1'b0;
    end else begin
      if (HREADY) begin
        pend_wr_reg   <= HSEL && HTRANS[1] && HWRITE;
        pend_addr_reg <= HADDR[4:2];
      end
      if (commit) begin
        case (pend_addr_reg)
          3'd0:    ctrl_reg     <= HWDATA[3:0] & CTRL_MASK;
          3'd1:    interval_reg <= HWDATA[CNT_W-1:0];
          3'd2:    dpstage_reg  <= HWDATA[7:0];
          3'd4:    if (HWDATA[16]) ovf_reg <= 1'b0;
          default: ;
        endcase
      end
      if (push_req && !push_ok) ovf_reg <= 1'b1;
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (pop) rd_ptr_reg <= rd_ptr_reg + PW'(1);
      if (loop_push || push_ok) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      count_reg <= count_next;
    end
  end

  always_ff @(posedge HCLK) begin
    if (!HRESET) begin
      if (loop_push)    mem[wr_ptr_reg] <= mem[rd_ptr_reg];
      else if (push_ok) mem[wr_ptr_reg] <= {dpstage_reg, HWDATA};
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_reg       <= IDLE;
      cnt_reg         <= '0;
      disp_number_reg <= 32'd0;
      disp_dp_reg     <= 8'd0;
      disp_blank_reg  <= 1'b1;
    end else begin
      case (state_reg)
        IDLE: begin
          if (en && !empty) state_reg <= LOAD;
          if (empty && ctrl_reg[2]) disp_blank_reg <= 1'b1;
        end
        LOAD: begin
          if (!en) begin
            state_reg <= IDLE;
          end else begin
            if (pop) begin
              disp_number_reg <= mem[rd_ptr_reg][31:0];
              disp_dp_reg     <= mem[rd_ptr_reg][39:32];
              disp_blank_reg  <= 1'b0;
            end
            cnt_reg   <= dwell_load;
            state_reg <= DWELL;
          end
        end
        DWELL: begin
          if (!en) state_reg <= IDLE;
          else if (cnt_reg == CNT_W'(1)) state_reg <= empty ? IDLE : LOAD;
          else cnt_reg <= cnt_reg - CNT_W'(1);
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign disp_number = disp_number_reg;
  assign disp_dp     = disp_dp_reg;
  assign disp_blank  = disp_blank_reg;

`ifdef DISP_SEQ_IRQ_EN
  logic irq_reg;
  always_ff @(posedge HCLK) begin
    if (HRESET) irq_reg <= 1'b0;
    else        irq_reg <= ctrl_reg[3] && en && empty && (state_reg == IDLE);
  end
  assign irq = irq_reg;
`else
  assign irq = 1'b0;
`endif

  always_comb begin
    HRDATA = '0;
    case (pend_addr_reg)
      3'd0: HRDATA = 32'(ctrl_reg);
      3'd1: HRDATA = 32'(interval_reg);
      3'd2: HRDATA = 32'(dpstage_reg);
      3'd3: HRDATA = disp_number_reg;
      3'd4: begin
        HRDATA[CW-1:0] = count_reg;
        HRDATA[8]      = empty;
        HRDATA[9]      = full;
        HRDATA[10]     = (state_reg != IDLE);
        HRDATA[16]     = ovf_reg;
      end
      default: HRDATA = '0;
    endcase
  end

endmodule

// File: tb/tb_ahb_disp_sequencer.sv
// Bench for ahb_disp_sequencer: queue-based behavioural model checked every cycle plus directed literals.
module tb_ahb_disp_sequencer;

  localparam int DEPTH = 8;
  localparam int CNT_W = 24;

  logic        HCLK = 1'b0;
  logic        HRESET = 1'b1;
  logic        HSEL = 1'b0;
  logic        HREADY;
  logic [31:0] HADDR = 32'd0;
  logic [1:0]  HTRANS = 2'd0;
  logic        HWRITE = 1'b0;
  logic [31:0] HWDATA = 32'd0;
  logic [31:0] HRDATA;
  logic        HREADYOUT;
  logic [31:0] disp_number;
  logic [7:0]  disp_dp;
  logic        disp_blank;
  logic        irq;

  int tests = 0;
  int fails = 0;

  ahb_disp_sequencer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HREADY(HREADY), .HADDR(HADDR),
    .HTRANS(HTRANS), .HWRITE(HWRITE), .HWDATA(HWDATA), .HRDATA(HRDATA),
    .HREADYOUT(HREADYOUT), .disp_number(disp_number), .disp_dp(disp_dp),
    .disp_blank(disp_blank), .irq(irq)
  );

  assign HREADY = HREADYOUT;
  always #5 HCLK = ~HCLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [39:0]      mq[$];
  bit               m_valid = 0;
  bit               m_run;
  int               m_pop_in;
  logic [3:0]       m_ctrl;
  logic [CNT_W-1:0] m_ival;
  logic [7:0]       m_dps;
  logic             m_ovf;
  logic [31:0]      m_num;
  logic [7:0]       m_dp;
  logic             m_blank, m_irq;
  logic             m_pw, m_pr;
  logic [2:0]       m_pa;

  function automatic logic m_ready();
    return !(m_pw && m_pa == 3'd3 && m_run && m_pop_in == 1 && m_ctrl[0] && m_ctrl[1]);
  endfunction

  function automatic logic [31:0] m_rdata();
    int sz;
    sz = mq.size();
    case (m_pa)
      3'd0: return 32'(m_ctrl);
      3'd1: return 32'(m_ival);
      3'd2: return 32'(m_dps);
      3'd3: return m_num;
      3'd4: return {15'd0, m_ovf, 5'd0, m_run, (sz == DEPTH), (sz == 0), 3'd0, 5'(sz)};
      default: return 32'd0;
    endcase
  endfunction

  always @(posedge HCLK) begin : model
    logic rdy, pop, commit;
    int sz;
    logic [39:0] f;
    if (HRESET) begin
      mq.delete();
      m_valid = 1; m_run = 0; m_pop_in = 0;
      m_ctrl = 0; m_ival = 0; m_dps = 0; m_ovf = 0;
      m_num = 0; m_dp = 0; m_blank = 1; m_irq = 0;
      m_pw = 0; m_pr = 0; m_pa = 0;
    end else begin
      rdy = m_ready();
      commit = m_pw && rdy;
      sz = mq.size();
      pop = 0;
`ifdef DISP_SEQ_IRQ_EN
      m_irq = m_ctrl[3] && m_ctrl[0] && sz == 0 && !m_run;
`else
      m_irq = 0;
`endif
      if (!m_run && sz == 0 && m_ctrl[2]) m_blank = 1;
      // m_pop_in counts edges until the next frame reaches the display
      if (!m_ctrl[0]) m_run = 0;
      else if (!m_run) begin
        if (sz != 0) begin m_run = 1; m_pop_in = 1; end
      end
      else if (m_pop_in == 1) pop = 1;
      else if (m_pop_in == 2 && sz == 0) m_run = 0;
      else m_pop_in--;
      if (pop) begin
        f = mq.pop_front();
        m_num = f[31:0]; m_dp = f[39:32]; m_blank = 0;
        if (m_ctrl[1]) mq.push_back(f);
        m_pop_in = ((m_ival == 0) ? 1 : int'(m_ival)) + 1;
      end
      if (commit) begin
        case (m_pa)
`ifdef DISP_SEQ_IRQ_EN
          3'd0: m_ctrl = HWDATA[3:0];
`else
          3'd0: m_ctrl = HWDATA[3:0] & 4'h7;
`endif
          3'd1: m_ival = HWDATA[CNT_W-1:0];
          3'd2: m_dps = HWDATA[7:0];
          3'd3: if (mq.size() < DEPTH) mq.push_back({m_dps, HWDATA}); else m_ovf = 1;
          3'd4: if (HWDATA[16]) m_ovf = 0;
          default: ;
        endcase
      end
      if (rdy) begin
        m_pw = HSEL && HTRANS[1] && HWRITE;
        m_pr = HSEL && HTRANS[1] && !HWRITE;
        m_pa = HADDR[4:2];
      end
    end
  end

  always @(negedge HCLK) begin
    if (m_valid) begin
      chk("disp_number", disp_number, m_num);
      chk("disp_dp", 32'(disp_dp), 32'(m_dp));
      chk("disp_blank", 32'(disp_blank), 32'(m_blank));
      chk("irq", 32'(irq), 32'(m_irq));
      chk("hreadyout", 32'(HREADYOUT), 32'(m_ready()));
      if (m_pr && m_ready()) chk("hrdata", HRDATA, m_rdata());
    end
  end

  // ---------------- bus tasks ----------------
  task automatic wait_ready(input string name);
    int n;
    n = 0;
    while (!HREADYOUT && n < 4) begin @(posedge HCLK); #1; n++; end
    if (n >= 4) begin
      tests++; fails++;
      $display("FAIL %s: HREADYOUT still 0 after %0d cycles, required 1", name, n);
    end
  endtask

  task automatic ahb_write(input logic [7:0] a, input logic [31:0] d, output int ws);
    HSEL = 1; HTRANS = 2'b10; HWRITE = 1; HADDR = 32'(a);
    @(posedge HCLK); #1;
    HSEL = 0; HTRANS = 2'b00; HWRITE = 0; HWDATA = d;
    ws = 0;
    while (!HREADYOUT && ws < 4) begin @(posedge HCLK); #1; ws++; end
    if (ws >= 4) begin
      tests++; fails++;
      $display("FAIL write_wait: HREADYOUT still 0 after %0d cycles, required 1", ws);
    end
    @(posedge HCLK); #1;
  endtask

  task automatic ahb_read(input logic [7:0] a, output logic [31:0] d);
    HSEL = 1; HTRANS = 2'b10; HWRITE = 0; HADDR = 32'(a);
    @(posedge HCLK); #1;
    HSEL = 0; HTRANS = 2'b00;
    wait_ready("read_wait");
    d = HRDATA;
    @(posedge HCLK); #1;
  endtask

  task automatic do_reset();
    HRESET = 1; HSEL = 0; HTRANS = 0; HWRITE = 0;
    repeat (2) @(posedge HCLK);
    #1;
    HRESET = 0;
    chk("rst_blank", 32'(disp_blank), 32'd1);
    chk("rst_number", disp_number, 32'd0);
    chk("rst_hreadyout", 32'(HREADYOUT), 32'd1);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    int ws, ws_d;
    logic [31:0] rd;
    logic [31:0] seq_num [3];
    logic [7:0]  seq_dp [3];
    bit saw9;

    seq_num[0] = 32'hAAAA0001; seq_num[1] = 32'hBBBB0002; seq_num[2] = 32'hCCCC0003;
    seq_dp[0] = 8'h01; seq_dp[1] = 8'h02; seq_dp[2] = 8'h04;

    // reset values
    do_reset();
    ahb_read(8'h10, rd); chk("rst_status", rd, 32'h0000_0100);
    ahb_read(8'h00, rd); chk("rst_ctrl", rd, 32'h0);

    // single frame, two-cycle latency, dwell then idle with display held
    ahb_write(8'h08, 32'h81, ws_d);
    ahb_write(8'h04, 32'd4, ws_d);
    ahb_write(8'h00, 32'h1, ws_d);
    ahb_write(8'h0C, 32'h12345678, ws_d);
    @(posedge HCLK); #1;
    chk("latency_1cyc", disp_number, 32'h0);
    @(posedge HCLK); #1;
    chk("latency_2cyc", disp_number, 32'h12345678);
    chk("frame_dp", 32'(disp_dp), 32'h81);
    repeat (6) @(posedge HCLK);
    #1;
    ahb_read(8'h10, rd); chk("idle_status", rd, 32'h0000_0100);
    ahb_read(8'h0C, rd); chk("held_frame", rd, 32'h12345678);
    chk("held_unblanked", 32'(disp_blank), 32'd0);
    ahb_write(8'h00, 32'h5, ws_d);
    @(posedge HCLK); #1;
    chk("blank_empty", 32'(disp_blank), 32'd1);

    // loop slideshow A,B,C at 3+1 cycles each
    do_reset();
    ahb_write(8'h04, 32'd3, ws_d);
    for (int k = 0; k < 3; k++) begin
      ahb_write(8'h08, 32'(seq_dp[k]), ws_d);
      ahb_write(8'h0C, seq_num[k], ws_d);
    end
    ahb_write(8'h00, 32'h3, ws_d);
    for (int i = 1; i <= 16; i++) begin
      @(posedge HCLK); #1;
      if (i >= 2) begin
        chk("loop_number", disp_number, seq_num[((i - 2) / 4) % 3]);
        chk("loop_dp", 32'(disp_dp), 32'(seq_dp[((i - 2) / 4) % 3]));
      end
    end
    ahb_read(8'h10, rd); chk("loop_status", rd, 32'h0000_0403);

    // DATA write landing on a loop LOAD cycle (reset hits mid-dwell)
    do_reset();
    ahb_write(8'h04, 32'd3, ws_d);
    for (int k = 0; k < 3; k++) ahb_write(8'h0C, seq_num[k], ws_d);
    ahb_write(8'h00, 32'h3, ws_d);
    ahb_write(8'h0C, 32'hDDDD0004, ws);
    chk("stall_waits", 32'(ws), 32'd1);
    ahb_read(8'h10, rd); chk("stall_status", rd, 32'h0000_0404);

    // overflow, sticky OVF clear, push freed by same-cycle pop
    do_reset();
    for (int k = 1; k <= 9; k++) ahb_write(8'h0C, 32'hF000_0000 + 32'(k), ws_d);
    ahb_read(8'h10, rd); chk("ovf_status", rd, 32'h0001_0208);
    ahb_write(8'h10, 32'h0001_0000, ws_d);
    ahb_read(8'h10, rd); chk("ovf_cleared", rd, 32'h0000_0208);
    ahb_write(8'h04, 32'd0, ws_d);
    ahb_write(8'h00, 32'h1, ws_d);
    ahb_write(8'h0C, 32'hF000_000A, ws);
    chk("pop_push_waits", 32'(ws), 32'd0);
    ahb_read(8'h10, rd); chk("pop_push_status", rd, 32'h0000_0608);
    saw9 = 0;
    for (int i = 0; i < 50; i++) begin
      @(posedge HCLK); #1;
      if (disp_number == 32'hF000_0009) saw9 = 1;
    end
    chk("dropped_never_shown", 32'(saw9), 32'd0);
    chk("drain_last", disp_number, 32'hF000_000A);
    ahb_read(8'h10, rd); chk("drain_status", rd, 32'h0000_0100);

    // interrupt on drained queue
    do_reset();
    ahb_write(8'h04, 32'd2, ws_d);
    ahb_write(8'h0C, 32'h5555AAAA, ws_d);
    ahb_write(8'h00, 32'hD, ws_d);
    repeat (10) @(posedge HCLK);
    #1;
`ifdef DISP_SEQ_IRQ_EN
    chk("irq_drained", 32'(irq), 32'd1);
`else
    chk("irq_drained", 32'(irq), 32'd0);
`endif
    chk("irq_blank", 32'(disp_blank), 32'd1);
    ahb_write(8'h0C, 32'h6666BBBB, ws_d);
    repeat (3) @(posedge HCLK);
    #1;
    chk("irq_refilled", 32'(irq), 32'd0);
    chk("irq_frame", disp_number, 32'h6666BBBB);

    repeat (2) @(posedge HCLK);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
